piso_arb_ctrl: RTL

Serial transmit controller that shares one parallel-in/serial-out lane between two requesters. It arbitrates round-robin, accepts a DATA_W-bit word over a valid/ready handshake, and shifts it out LSB first. Each bit is held for a programmable number of clock cycles. It sits between the producer blocks and the single serial pin/link, and supplies the framing and completion strobes.

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_bit_timer.sv | 30 +++
 rtl/piso_arb_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the serial transmit controller.
//   state_e          : controller FSM states
//   PISO_DATA_W/DIV_W: default word width and bit-period divider width
//   REQ0/REQ1        : requester identifiers as driven on id_o
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int PISO_DATA_W = 4;
  localparam int PISO_DIV_W  = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/piso_bit_timer.sv
// Bit-period down-counter.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i, val_i : load val_i into the counter (takes priority)
//   en_i          : decrement by one; holds at zero
//   cnt_o         : current count
//   tc_o          : terminal count (count == 0)
module piso_bit_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DIV_W-1:0] val_i,
  input  logic             en_i,
  output logic [DIV_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  cnt_q <= '0;
    else if (load_i)              cnt_q <= val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - DIV_W'(1);
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/piso_arb_ctrl.sv
// Two-requester round-robin serial transmitter.
//   clk_i, rst_ni          : clock, async active-low reset
//   reqN_valid/data/ready  : valid/ready word input from requester N
//   div_i                  : bit period minus one, captured at accept
//   data_o                 : serial data, LSB first (0 outside a frame)
//   frame_o                : high while word bits are on data_o
//   id_o                   : requester of the current/last frame
//   done_o                 : pulse on the final cycle of the final bit
module piso_arb_ctrl
  import piso_pkg::*;
#(
  parameter int DATA_W = PISO_DATA_W,
  parameter int DIV_W  = PISO_DIV_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  input  logic [DIV_W-1:0]  div_i,
  output logic              data_o,
  output logic              frame_o,
  output logic              id_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic              id_q;
  logic              last_grant_q;

  logic              grant;
  logic              accept;
  logic              in_shift;
  logic              last_bit;
  logic              tc;
  logic              bit_step;
  logic              tmr_load;
  logic [DIV_W-1:0]  tmr_val;
  logic [DIV_W-1:0]  div_cnt;

  // Round-robin: a lone requester wins outright; on a tie the one that
  // did not win last time goes next.
  always_comb begin
    grant = REQ0;
    if (req0_valid_i && req1_valid_i) grant = ~last_grant_q;
    else if (req1_valid_i)            grant = REQ1;
  end

  // Readies are gated by rst_ni so they read 0 while reset is held,
  // even though the FSM already sits in IDLE.
  assign accept       = rst_ni && (state_q == IDLE) && (req0_valid_i || req1_valid_i);
  assign req0_ready_o = rst_ni && (state_q == IDLE) && (grant == REQ0) && req0_valid_i;
  assign req1_ready_o = rst_ni && (state_q == IDLE) && (grant == REQ1) && req1_valid_i;

  assign in_shift = (state_q == SHIFT);
  assign last_bit = (bit_cnt_q == CNT_W'(DATA_W-1));
  assign bit_step = in_shift && tc && !last_bit;

  // Bit timer is loaded from div_i at accept and from the captured copy
  // at every bit boundary, so div_i changes mid-frame have no effect.
  assign tmr_load = accept || bit_step;
  assign tmr_val  = accept ? div_i : div_q;

  piso_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .en_i   (in_shift && !tc),
    .cnt_o  (div_cnt),
    .tc_o   (tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (tc && last_bit) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      div_q        <= '0;
      id_q         <= REQ0;
      last_grant_q <= REQ1;
    end else if (accept) begin
      shift_q      <= (grant == REQ1) ? req1_data_i : req0_data_i;
      bit_cnt_q    <= '0;
      div_q        <= div_i;
      id_q         <= grant;
      last_grant_q <= grant;
    end else if (bit_step) begin
      shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  // Outputs decode straight from state so an async reset clears them
  // immediately.
  assign frame_o = in_shift;
  assign data_o  = in_shift && shift_q[0];
  assign done_o  = in_shift && tc && last_bit;
  assign id_o    = id_q;

endmodule
